trig_frame_rx: RTL and testbench
================================

Name: trig_frame_rx

Overview:
- Upstream feeder for the command decoder.
- Receives an asynchronous 8N1 serial byte stream and packs up to four symbol bytes of one command frame into the Trig_1..Trig_4 registers.
- A terminator byte ends the frame. On it, the block publishes the frame and strobes the active-low priem line that the decoder samples.
- Owns bit timing, frame assembly and error discard, so the decoder only ever sees complete, stable frames.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit. Must be at least 4.
- TERM, 8'h0D, terminator byte value. Never stored in a slot.
- PRIEM_LEN, 2, cycles priem is held low per publish. Must be at least 1 and less than 10*CLKS_PER_BIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial line, idle high; already synchronised by the top level.
- Trig_1  out  8  first symbol of the last published frame.
- Trig_2  out  8  second symbol.
- Trig_3  out  8  third symbol.
- Trig_4  out  8  fourth symbol.
- priem  out  1  active-low publish strobe; idle high.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- busy  out  1  high while a frame is partially assembled.

Behaviour:
- Reset (on rst at a rising edge, regardless of state):
  - Trig_1..4 = 0, priem = 1, frame_err = 0, busy = 0.
  - Slot count = 0, receiver to IDLE.
  - A reset mid-byte or mid-frame discards all partial data; nothing is published.
- Byte receiver states: IDLE, START, DATA, STOP.
  - IDLE: rx low moves to START, and the cycle counter restarts.
  - START: sample rx at CLKS_PER_BIT/2. If rx is high, treat it as a glitch and return to IDLE with no error. Otherwise go to DATA.
  - DATA: sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample.
  - STOP: sample rx CLKS_PER_BIT after bit 7.
    - rx high: byte_valid pulses for 1 cycle on the next cycle.
    - rx low: byte_err pulses instead.
    - Either way, return to IDLE after the stop sample. A new start bit is accepted immediately.
- Assembler states: COLLECT, DISCARD.
  - COLLECT, data byte (not TERM), count < 4: write it to slot[count] and increment count. busy = 1.
  - COLLECT, data byte, count = 4 (overflow): pulse frame_err, clear count and slots, go to DISCARD.
  - COLLECT, TERM with count = 0: ignored; no publish, no error.
  - COLLECT, TERM with count 1..4, i.e. publish:
    - On the next edge, Trig_k = slot k for each k, with unfilled slots driven as 8'h00.
    - priem goes low in that same cycle and stays low for exactly PRIEM_LEN cycles.
    - Count and slots clear; busy = 0.
  - DISCARD: every byte except TERM is ignored. TERM returns the assembler to COLLECT without publishing.
  - byte_err in any state: pulse frame_err, clear count and slots, go to DISCARD. If the frame was empty, go to COLLECT instead.
- Output stability: Trig_1..4 change only on a publish edge; they hold through priem low and until the next publish.
- Latency: stop-bit sample of TERM at cycle T; byte_valid at T+1; Trig update and priem falling at T+2.
- Simultaneous events: a publish cannot overlap the next byte's byte_valid (enforced by the PRIEM_LEN bound). rst wins over everything.
- Slot index is 2 bits. Count saturates check at 4; no wrap-around.

Decomposition:
- Package trig_rx_pkg holds:
  - the receiver state enum (IDLE, START, DATA, STOP);
  - the assembler state enum (COLLECT, DISCARD);
  - MAX_SYMBOLS = 4;
  - default TERM.
- One sub-module, rx_byte: bit timing and byte receiver, with outputs data[7:0], byte_valid and byte_err.
- trig_frame_rx instantiates rx_byte and contains the assembler and output registers.

Test Plan (CLKS_PER_BIT=16, TERM=0D, PRIEM_LEN=2):
- Bytes 7E,33,5B,1B,0D -> Trig_1..4 = 7E,33,5B,1B; priem low exactly 2 cycles starting 2 cycles after the 0D stop sample; frame_err stays 0.
- Bytes 44,5B,0D, then 41,1B,0D -> first publish Trig = 44,5B,00,00; second Trig = 41,1B,00,00; two separate 2-cycle priem pulses.
- Bytes 01,02,03,04,05,06,0D after a prior publish of 7E,33,5B,1B -> one frame_err pulse on byte 05; no priem; Trig stays 7E,33,5B,1B.
- rx low for 4 cycles then high, followed by 08,0D -> glitch ignored; Trig = 08,00,00,00; single publish.
- Byte 33 then a byte with stop bit low, then 0D -> frame_err pulses; the DISCARD path is exercised and no publish occurs.
- A following 08,0D frame publishes normally -> Trig = 08,00,00,00.
- rst high for 1 cycle mid-DATA of the second byte of 7E,33,0D -> Trig = 0, priem = 1, busy = 0; the remaining bits and 0D cause no publish.

Source files
------------

// File: rtl/trig_rx_pkg.sv
// Shared types and constants for the trigger frame receiver.
package trig_rx_pkg;

    // Serial byte receiver states.
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    // Frame assembler states.
    typedef enum logic {
        StCollect,
        StDiscard
    } asm_state_e;

    localparam int unsigned MAX_SYMBOLS  = 4;
    localparam logic [7:0]  DEFAULT_TERM = 8'h0D;

endpackage

// File: rtl/rx_byte.sv
// 8N1 byte receiver: start-bit qualification, mid-bit sampling, stop-bit check.
module rx_byte
    import trig_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    // Receiver state, bit timer and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state: the start bit is checked half a bit in, then every bit mid-cell.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A high line here was only a glitch.
                    state_d = rx ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    valid_d = rx;
                    err_d   = !rx;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data       = shift_q;
    assign byte_valid = valid_q;
    assign byte_err   = err_q;

endmodule

// File: rtl/trig_frame_rx.sv
// Serial command-frame receiver: packs up to four symbols and publishes on terminator.
module trig_frame_rx
    import trig_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  TERM         = DEFAULT_TERM,
    parameter int unsigned PRIEM_LEN    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] Trig_1,
    output logic [7:0] Trig_2,
    output logic [7:0] Trig_3,
    output logic [7:0] Trig_4,
    output logic       priem,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] PcntInit = 16'(PRIEM_LEN - 1);
    localparam logic [2:0]  MaxCnt   = 3'(MAX_SYMBOLS);

    logic [7:0] rx_data;
    logic       byte_valid;
    logic       byte_err;

    rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (rx_data),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    asm_state_e                        asm_q, asm_d;
    logic [2:0]                        count_q, count_d;
    logic [MAX_SYMBOLS-1:0][7:0]       slot_q, slot_d;
    logic [MAX_SYMBOLS-1:0][7:0]       trig_q, trig_d;
    logic                              priem_q, priem_d;
    logic [15:0]                       pcnt_q, pcnt_d;
    logic                              ferr_q, ferr_d;

    // Assembler state, frame slots and published outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q   <= StCollect;
            count_q <= '0;
            slot_q  <= '0;
            trig_q  <= '0;
            priem_q <= 1'b1;
            pcnt_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            count_q <= count_d;
            slot_q  <= slot_d;
            trig_q  <= trig_d;
            priem_q <= priem_d;
            pcnt_q  <= pcnt_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state: frame assembly, publish and discard handling.
    always_comb begin
        asm_d   = asm_q;
        count_d = count_q;
        slot_d  = slot_q;
        trig_d  = trig_q;
        priem_d = priem_q;
        pcnt_d  = pcnt_q;
        ferr_d  = 1'b0;

        // Hold priem low for PRIEM_LEN cycles after a publish.
        if (!priem_q) begin
            if (pcnt_q != '0) begin
                pcnt_d = pcnt_q - 16'd1;
            end else begin
                priem_d = 1'b1;
            end
        end

        if (byte_err) begin
            ferr_d  = 1'b1;
            count_d = '0;
            slot_d  = '0;
            asm_d   = (count_q == '0) ? StCollect : StDiscard;
        end else if (byte_valid) begin
            unique case (asm_q)
                StCollect: begin
                    if (rx_data == TERM) begin
                        // An empty frame terminator is silently ignored.
                        if (count_q != '0) begin
                            trig_d  = slot_q;
                            priem_d = 1'b0;
                            pcnt_d  = PcntInit;
                            count_d = '0;
                            slot_d  = '0;
                        end
                    end else if (count_q == MaxCnt) begin
                        ferr_d  = 1'b1;
                        count_d = '0;
                        slot_d  = '0;
                        asm_d   = StDiscard;
                    end else begin
                        slot_d[count_q[1:0]] = rx_data;
                        count_d              = count_q + 3'd1;
                    end
                end
                StDiscard: begin
                    if (rx_data == TERM) begin
                        asm_d = StCollect;
                    end
                end
                default: asm_d = StCollect;
            endcase
        end
    end

    assign Trig_1    = trig_q[0];
    assign Trig_2    = trig_q[1];
    assign Trig_3    = trig_q[2];
    assign Trig_4    = trig_q[3];
    assign priem     = priem_q;
    assign frame_err = ferr_q;
    assign busy      = (count_q != '0);

endmodule

// File: tb/tb_trig_frame_rx.sv
// Directed bench for trig_frame_rx: publish, partial frames, overflow, glitch, errors, reset.
module tb_trig_frame_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] trig_1, trig_2, trig_3, trig_4;
    logic       priem, frame_err, busy;

    int checks = 0;
    int errors = 0;

    // Line activity observed at each falling edge.
    int   pulses   = 0;
    int   errs     = 0;
    int   run      = 0;
    int   last_len = 0;
    logic prev_priem = 1'b1;
    time  fall_time  = 0;
    time  start_time = 0;

    int p0, e0;

    always #5 clk = ~clk;

    trig_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .TERM        (8'h0D),
        .PRIEM_LEN   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .Trig_1   (trig_1),
        .Trig_2   (trig_2),
        .Trig_3   (trig_3),
        .Trig_4   (trig_4),
        .priem    (priem),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Count priem pulses, their length and frame_err pulses.
    always @(negedge clk) begin
        if (priem === 1'b0 && prev_priem === 1'b1) begin
            pulses    <= pulses + 1;
            fall_time <= $time;
            run       <= 1;
        end else if (priem === 1'b0) begin
            run <= run + 1;
        end
        if (priem === 1'b1 && prev_priem === 1'b0) begin
            last_len <= run;
        end
        if (frame_err === 1'b1) begin
            errs <= errs + 1;
        end
        prev_priem <= priem;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_trig(input string tag, input logic [31:0] exp);
        check({tag, "_t1"}, {24'h0, trig_1}, {24'h0, exp[31:24]});
        check({tag, "_t2"}, {24'h0, trig_2}, {24'h0, exp[23:16]});
        check({tag, "_t3"}, {24'h0, trig_3}, {24'h0, exp[15:8]});
        check({tag, "_t4"}, {24'h0, trig_4}, {24'h0, exp[7:0]});
    endtask

    // One 8N1 character; rst_bit >= 0 pulses rst at the start of that data bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int rst_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < int'(CPB); j++) begin
                @(negedge clk);
                if (j == 0) rx = f[i];
                if (i == 0 && j == 0) start_time = $time;
                if (rst_bit >= 0 && i == rst_bit + 1) begin
                    if (j == 1) begin
                        check("rst_trig1", {24'h0, trig_1}, 32'h0);
                        check("rst_priem", {31'h0, priem}, 32'h1);
                        check("rst_busy", {31'h0, busy}, 32'h0);
                    end
                    rst = (j == 0);
                end
            end
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1, -1);
    endtask

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_trig("reset", 32'h0);
        check("reset_priem", {31'h0, priem}, 32'h1);
        check("reset_ferr", {31'h0, frame_err}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Full four-symbol frame with latency and pulse width.
        p0 = pulses; e0 = errs;
        send(8'h7E);
        check("busy_after_first", {31'h0, busy}, 32'h1);
        send(8'h33); send(8'h5B); send(8'h1B); send(8'h0D);
        repeat (4) @(negedge clk);
        check_trig("full", 32'h7E335B1B);
        check("full_pulses", pulses - p0, 1);
        check("full_len", last_len, 2);
        check("full_latency", 32'(fall_time - start_time), 32'(154 * 10));
        check("full_ferr", errs - e0, 0);
        check("full_busy", {31'h0, busy}, 32'h0);

        // Two short frames back to back.
        p0 = pulses;
        send(8'h44); send(8'h5B); send(8'h0D);
        repeat (4) @(negedge clk);
        check_trig("short1", 32'h445B0000);
        check("short1_pulses", pulses - p0, 1);
        send(8'h41); send(8'h1B); send(8'h0D);
        repeat (4) @(negedge clk);
        check_trig("short2", 32'h411B0000);
        check("short2_pulses", pulses - p0, 2);
        check("short2_len", last_len, 2);

        // Overflow on the fifth symbol.
        send(8'h7E); send(8'h33); send(8'h5B); send(8'h1B); send(8'h0D);
        repeat (4) @(negedge clk);
        p0 = pulses; e0 = errs;
        send(8'h01);
        check("ovf_busy", {31'h0, busy}, 32'h1);
        send(8'h02); send(8'h03); send(8'h04);
        check("ovf_noerr_yet", errs - e0, 0);
        send(8'h05);
        check("ovf_err", errs - e0, 1);
        send(8'h06); send(8'h0D);
        repeat (4) @(negedge clk);
        check("ovf_err_total", errs - e0, 1);
        check("ovf_pulses", pulses - p0, 0);
        check_trig("ovf", 32'h7E335B1B);

        // Short low glitch on the line, then a one-symbol frame.
        @(negedge clk); rx = 1'b0;
        repeat (4) @(negedge clk); rx = 1'b1;
        repeat (20) @(negedge clk);
        p0 = pulses; e0 = errs;
        send(8'h08); send(8'h0D);
        repeat (4) @(negedge clk);
        check_trig("glitch", 32'h08000000);
        check("glitch_pulses", pulses - p0, 1);
        check("glitch_ferr", errs - e0, 0);

        // Bad stop bit mid-frame discards the frame.
        p0 = pulses; e0 = errs;
        send(8'h33);
        send_byte(8'h55, 1'b0, -1);
        send(8'h0D);
        repeat (4) @(negedge clk);
        check("stop_err", errs - e0, 1);
        check("stop_pulses", pulses - p0, 0);
        check("stop_busy", {31'h0, busy}, 32'h0);
        check_trig("stop", 32'h08000000);

        // Recovery frame publishes normally.
        p0 = pulses;
        send(8'h08); send(8'h0D);
        repeat (4) @(negedge clk);
        check_trig("recover", 32'h08000000);
        check("recover_pulses", pulses - p0, 1);

        // Reset in the middle of the second symbol.
        p0 = pulses;
        send(8'h7E);
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        send_byte(8'h33, 1'b1, 2);
        send(8'h0D);
        repeat (400) @(negedge clk);
        check("rst_pulses", pulses - p0, 0);
        check_trig("rst_after", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
